// File: rtl/split_tile_dispatcher.sv
// Walks the splitter's tile table and dispatches each leaf tile to the systolic
// tile engine, waiting for completion before fetching the next entry.
module split_tile_dispatcher #(
    parameter int OUT_SIZE = 64,
    parameter int ENTRY_W  = 145
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         last,
    output logic               rd_en,
    output logic [7:0]         rd_addr,
    input  logic [ENTRY_W-1:0] rd_data,
    output logic               tile_valid,
    input  logic               tile_ready,
    output logic [39:0]        tile_a,
    output logic [39:0]        tile_b,
    output logic [39:0]        tile_o,
    output logic               tile_acc,
    output logic [7:0]         tile_idx,
    input  logic               tile_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         n_tiles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EVAL,
        S_ISSUE,
        S_EXEC,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [39:0]       a;
        logic [39:0]       b;
        logic [39:0]       o;
        logic [7:0]        to_n1;
        logic [7:0]        to_n2;
        logic signed [8:0] parent;
    } entry_t;

    localparam logic [8:0] OUT_SIZE_W = 9'(OUT_SIZE);

    state_t      state_q, state_d;
    logic [7:0]  idx_q;
    logic [7:0]  last_q;
    entry_t      ent;
    logic        is_leaf;
    logic        last_entry;
    logic        too_big;
    logic        unused_fields;

    assign ent        = rd_data[$bits(entry_t)-1:0];
    // Children always sit at index >= 1, so a zero child link marks a leaf.
    assign is_leaf    = (ent.to_n1 == 8'd0);
    // Widened to 9 bits so idx = 255 cannot wrap back onto a small last.
    assign last_entry = (({1'b0, idx_q} + 9'd1) == {1'b0, last_q});
    assign too_big    = ({1'b0, last} > OUT_SIZE_W);

    // Sibling link and parent pointer are only needed by the splitter itself.
    assign unused_fields = ^{ent.to_n2, ent.parent};

    assign rd_en      = (state_q == S_RD);
    assign rd_addr    = idx_q;
    assign tile_valid = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (last == 8'd0 || too_big) state_d = S_DONE;
                    else                         state_d = S_RD;
                end
            end
            S_RD:   state_d = S_EVAL;
            S_EVAL: begin
                if (is_leaf)         state_d = S_ISSUE;
                else if (last_entry) state_d = S_DONE;
                else                 state_d = S_RD;
            end
            S_ISSUE: begin
                if (tile_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (tile_done) state_d = last_entry ? S_DONE : S_RD;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            n_tiles  <= '0;
            err      <= 1'b0;
            tile_a   <= '0;
            tile_b   <= '0;
            tile_o   <= '0;
            tile_acc <= 1'b0;
            tile_idx <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        last_q  <= last;
                        n_tiles <= '0;
                        err     <= too_big;
                    end
                end
                S_EVAL: begin
                    if (is_leaf) begin
                        tile_a   <= ent.a;
                        tile_b   <= ent.b;
                        tile_o   <= ent.o;
                        tile_acc <= (ent.a[29:20] != 10'd0);
                        tile_idx <= idx_q;
                    end else if (!last_entry) begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (tile_ready) n_tiles <= n_tiles + 8'd1;
                end
                S_EXEC: begin
                    if (tile_done && !last_entry) idx_q <= idx_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_split_tile_dispatcher.sv
// Directed bench for split_tile_dispatcher: a table memory model answers reads
// one cycle late and the main thread plays the tile engine.
module tb_split_tile_dispatcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   last;
    logic         rd_en;
    logic [7:0]   rd_addr;
    logic [144:0] rd_data;
    logic         tile_valid;
    logic         tile_ready;
    logic [39:0]  tile_a, tile_b, tile_o;
    logic         tile_acc;
    logic [7:0]   tile_idx;
    logic         tile_done;
    logic         busy, done, err;
    logic [7:0]   n_tiles;

    logic [144:0] mem [64];
    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0, done_cnt = 0, xfer_cnt = 0;

    always #5 clk = ~clk;

    split_tile_dispatcher #(.OUT_SIZE(64), .ENTRY_W(145)) dut (
        .clk(clk), .reset(reset), .start(start), .last(last),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_a(tile_a), .tile_b(tile_b), .tile_o(tile_o),
        .tile_acc(tile_acc), .tile_idx(tile_idx), .tile_done(tile_done),
        .busy(busy), .done(done), .err(err), .n_tiles(n_tiles)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[5:0]];
    end

    always @(posedge clk) begin
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (tile_valid && tile_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [39:0] f4(input int w0, input int l0, input int w1, input int l1);
        return {10'(w0), 10'(l0), 10'(w1), 10'(l1)};
    endfunction

    function automatic logic [144:0] mk(input logic [39:0] a, input logic [39:0] b,
                                        input logic [39:0] o, input logic [7:0] n1,
                                        input logic [7:0] n2);
        return {a, b, o, n1, n2, 9'h1FF};
    endfunction

    // Waits for a descriptor, checks it (also while stalled), accepts it and completes it.
    task automatic run_leaf(input string tag, input logic [39:0] ea, input logic [39:0] eb,
                            input logic [39:0] eo, input logic eacc, input logic [7:0] eidx,
                            input int stall);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (tile_valid) begin
                ok = 1;
                break;
            end
            step();
        end
        check({tag, "_valid_seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        check({tag, "_a"}, tile_a, ea);
        check({tag, "_b"}, tile_b, eb);
        check({tag, "_o"}, tile_o, eo);
        check({tag, "_acc"}, tile_acc, eacc);
        check({tag, "_idx"}, tile_idx, eidx);
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_hold_valid"}, tile_valid, 1);
            check({tag, "_hold_a"}, tile_a, ea);
            check({tag, "_hold_b"}, tile_b, eb);
            check({tag, "_hold_o"}, tile_o, eo);
            check({tag, "_hold_idx"}, tile_idx, eidx);
        end
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
        check({tag, "_valid_drop"}, tile_valid, 0);
        check({tag, "_exec_busy"}, busy, 1);
        step();
        check({tag, "_exec_a"}, tile_a, ea);
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
    endtask

    initial begin
        int rd0, dn0, xf0;
        reset = 1'b1; start = 1'b0; last = '0; tile_ready = 1'b0; tile_done = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) step();
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ntiles", n_tiles, 0);
        check("rst_valid", tile_valid, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_tile_a", tile_a, 0);

        // Stray tile_done while idle must do nothing.
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        check("stray_done_busy", busy, 0);
        check("stray_done_done", done, 0);

        // Single leaf with strict cycle timing.
        mem[0] = mk(f4(0, 0, 7, 19), f4(0, 0, 19, 4), f4(0, 0, 7, 4), 8'd0, 8'd0);
        last = 8'd1;
        pulse_start();
        check("t1_rd_en", rd_en, 1);
        check("t1_rd_addr", rd_addr, 0);
        check("t1_busy", busy, 1);
        step();
        check("t1_eval_valid", tile_valid, 0);
        step();
        check("t1_issue_valid", tile_valid, 1);
        run_leaf("t1", f4(0, 0, 7, 19), f4(0, 0, 19, 4), f4(0, 0, 7, 4), 1'b0, 8'd0, 0);
        check("t1_done", done, 1);
        check("t1_ntiles", n_tiles, 1);
        start = 1'b1;   // start during DONE is ignored
        step();
        start = 1'b0;
        check("t1_b2b_busy", busy, 0);
        check("t1_b2b_done", done, 0);
        check("t1_ntiles_kept", n_tiles, 1);

        // W split: root at 0, leaves at 1 and 2; extra start while in RD.
        mem[0] = mk(f4(0, 0, 20, 19), f4(0, 0, 19, 4), f4(0, 0, 20, 4), 8'd1, 8'd2);
        mem[1] = mk(f4(0, 0, 10, 19), f4(0, 0, 19, 4), f4(0, 0, 10, 4), 8'd0, 8'd0);
        mem[2] = mk(f4(10, 0, 20, 19), f4(0, 0, 19, 4), f4(10, 0, 20, 4), 8'd0, 8'd0);
        last = 8'd3;
        rd0 = rd_cnt;
        pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2_rd_start_busy", busy, 1);
        check("t2_rd_start_rd_en", rd_en, 0);
        run_leaf("t2_l1", f4(0, 0, 10, 19), f4(0, 0, 19, 4), f4(0, 0, 10, 4), 1'b0, 8'd1, 0);
        run_leaf("t2_l2", f4(10, 0, 20, 19), f4(0, 0, 19, 4), f4(10, 0, 20, 4), 1'b0, 8'd2, 0);
        check("t2_done", done, 1);
        check("t2_ntiles", n_tiles, 2);
        check("t2_reads", 64'(rd_cnt - rd0), 3);
        step();

        // K split: second leaf is a partial-K tile.
        mem[0] = mk(f4(0, 0, 7, 60), f4(0, 0, 60, 4), f4(0, 0, 7, 4), 8'd1, 8'd2);
        mem[1] = mk(f4(0, 0, 7, 30), f4(0, 0, 30, 4), f4(0, 0, 7, 4), 8'd0, 8'd0);
        mem[2] = mk(f4(0, 30, 7, 60), f4(30, 0, 60, 4), f4(0, 0, 7, 4), 8'd0, 8'd0);
        pulse_start();
        run_leaf("t3_l1", f4(0, 0, 7, 30), f4(0, 0, 30, 4), f4(0, 0, 7, 4), 1'b0, 8'd1, 0);
        run_leaf("t3_l2", f4(0, 30, 7, 60), f4(30, 0, 60, 4), f4(0, 0, 7, 4), 1'b1, 8'd2, 0);
        check("t3_done", done, 1);
        check("t3_ntiles", n_tiles, 2);
        step();

        // Backpressure: five stalled cycles, exactly one transfer.
        mem[0] = mk(f4(3, 5, 9, 11), f4(5, 2, 11, 8), f4(3, 2, 9, 8), 8'd0, 8'd0);
        last = 8'd1;
        xf0 = xfer_cnt;
        pulse_start();
        run_leaf("t4", f4(3, 5, 9, 11), f4(5, 2, 11, 8), f4(3, 2, 9, 8), 1'b1, 8'd0, 5);
        check("t4_done", done, 1);
        check("t4_xfers", 64'(xfer_cnt - xf0), 1);
        step();

        // Empty job and oversized job.
        last = 8'd0;
        rd0 = rd_cnt;
        pulse_start();
        check("t5_empty_done", done, 1);
        check("t5_empty_ntiles", n_tiles, 0);
        check("t5_empty_err", err, 0);
        step();
        check("t5_empty_idle", busy, 0);
        check("t5_empty_reads", 64'(rd_cnt - rd0), 0);
        last = 8'd70;
        pulse_start();
        check("t5_big_done", done, 1);
        check("t5_big_err", err, 1);
        step();
        check("t5_big_err_sticky", err, 1);
        check("t5_big_done_drop", done, 0);
        check("t5_big_reads", 64'(rd_cnt - rd0), 0);

        // Reset while executing a tile: everything clears, no done pulse.
        mem[0] = mk(f4(1, 0, 4, 6), f4(0, 0, 6, 2), f4(1, 0, 4, 2), 8'd0, 8'd0);
        last = 8'd1;
        pulse_start();
        check("t6_err_cleared", err, 0);
        step();
        step();
        check("t6_valid", tile_valid, 1);
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
        check("t6_in_exec_ntiles", n_tiles, 1);
        dn0 = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ntiles", n_tiles, 0);
        check("t6_rst_tile_a", tile_a, 0);
        check("t6_rst_tile_idx", tile_idx, 0);
        check("t6_rst_valid", tile_valid, 0);
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        step();
        check("t6_no_done", 64'(done_cnt - dn0), 0);
        check("t6_still_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
